// File: rtl/musb_shifter_pipe_pkg.sv
// Shared definitions for the pipelined MUSB shift/rotate unit.
// Optional feature macro: MUSB_SHIFTER_ROTATE_EN (enables ROR/ROL).
package musb_shifter_pipe_pkg;

   // in_op encodings, kept alongside the ALU operation codes
   localparam logic [2:0] SHIFT_OP_SRL = 3'b000;
   localparam logic [2:0] SHIFT_OP_SRA = 3'b001;
   localparam logic [2:0] SHIFT_OP_SLL = 3'b010;
   localparam logic [2:0] SHIFT_OP_ROR = 3'b100;
   localparam logic [2:0] SHIFT_OP_ROL = 3'b110;

   // Decoded controls carried down the pipe
   typedef struct packed {
      logic left;   // operand/result bit-reversed around a right shift
      logic arith;  // fill with the operand sign bit
      logic rot;    // wrap shifted-out bits back in at the top
      logic pass;   // reserved code: result is the operand unshifted
   } shift_ctrl_t;

   function automatic shift_ctrl_t decode_op(input logic [2:0] op);
      shift_ctrl_t c;
`ifndef MUSB_SHIFTER_ROTATE_EN
      logic unused_op;
`endif
      c = '0;
`ifdef MUSB_SHIFTER_ROTATE_EN
      unique case (op)
         SHIFT_OP_SRL: c = '0;
         SHIFT_OP_SRA: c.arith = 1'b1;
         SHIFT_OP_SLL: c.left = 1'b1;
         SHIFT_OP_ROR: c.rot = 1'b1;
         SHIFT_OP_ROL: begin
            c.rot  = 1'b1;
            c.left = 1'b1;
         end
         default: c.pass = 1'b1;
      endcase
`else
      // Without rotate support op[2] is ignored: ROR/ROL fall back to SRL/SLL
      unused_op = op[2];
      unique case (op[1:0])
         2'b00:   c = '0;
         2'b01:   c.arith = 1'b1;
         2'b10:   c.left = 1'b1;
         default: c.pass = 1'b1;
      endcase
`endif
      return c;
   endfunction

endpackage

// File: rtl/musb_shift_stage.sv
// Combinational slice of the right-shift network: levels FIRST_LEVEL ..
// FIRST_LEVEL+NUM_LEVELS-1, level k shifting by 2^k when shamnt[k] is set.
// Optional feature macro: MUSB_SHIFTER_ROTATE_EN (wrap-around feedback).
module musb_shift_stage #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned FIRST_LEVEL = 0,
   parameter int unsigned NUM_LEVELS  = 1,
   localparam int unsigned SHW        = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamnt,
   input  logic             fill,
   input  logic             rot,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] ins;
   int unsigned      amt;
   logic             lvl_bit;

`ifndef MUSB_SHIFTER_ROTATE_EN
   logic unused_rot;
   assign unused_rot = rot;
`endif

   // Cascade of binary mux levels with fill or wrap-around insertion
   always_comb begin
      cur     = data_in;
      ins     = '0;
      amt     = 0;
      lvl_bit = 1'b0;
      for (int k = 0; k < int'(NUM_LEVELS); k++) begin
         amt     = 32'd1 << (FIRST_LEVEL + k);
         lvl_bit = |(shamnt & (SHW'(1) << (FIRST_LEVEL + k)));
         ins     = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
`ifdef MUSB_SHIFTER_ROTATE_EN
         if (rot) ins = cur << (WIDTH - amt);
`endif
         if (lvl_bit) cur = (cur >> amt) | ins;
      end
      data_out = cur;
   end

endmodule

// File: rtl/musb_shifter_pipe.sv
// Pipelined shift/rotate unit with valid/ready handshake and flush.
// Left operations are done as bit-reverse, right shift, bit-reverse.
// Optional feature macro: MUSB_SHIFTER_ROTATE_EN (enables ROR/ROL).
module musb_shifter_pipe
   import musb_shifter_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   localparam int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamnt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam int unsigned LPS  = (SHW + STAGES - 1) / STAGES;
   localparam int unsigned LAST = STAGES - 1;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int b = 0; b < int'(WIDTH); b++) r[b] = x[WIDTH-1-b];
      return r;
   endfunction

   // Stage registers
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] fill_q;
   logic [STAGES-1:0] rot_q;
   logic [STAGES-1:0] left_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [SHW-1:0]    sham_q [STAGES];

   // Per-stage sources and slice results
   logic [STAGES-1:0] src_vld;
   logic [STAGES-1:0] src_fill;
   logic [STAGES-1:0] src_rot;
   logic [STAGES-1:0] src_left;
   logic [WIDTH-1:0]  src_data [STAGES];
   logic [SHW-1:0]    src_sham [STAGES];
   logic [WIDTH-1:0]  slice_out [STAGES];
   logic [WIDTH-1:0]  nxt_data [STAGES];

   // load_ext[i]: stage i may take new contents; entry STAGES is the consumer
   logic [STAGES:0]   load_ext;
   logic [STAGES-1:0] adv;

   shift_ctrl_t ctrl;
   assign ctrl = decode_op(in_op);

   for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
      localparam int unsigned FIRST = g * LPS;
      localparam int unsigned NUM   = (FIRST >= SHW) ? 0 :
                                      ((SHW - FIRST < LPS) ? (SHW - FIRST) : LPS);

      if (g == 0) begin : g_src_in
         assign src_vld[g]  = in_valid;
         assign src_data[g] = ctrl.left ? bit_rev(in_data) : in_data;
         assign src_sham[g] = ctrl.pass ? '0 : in_shamnt;
         assign src_fill[g] = ctrl.arith & in_data[WIDTH-1];
         assign src_rot[g]  = ctrl.rot;
         assign src_left[g] = ctrl.left;
      end else begin : g_src_reg
         assign src_vld[g]  = vld_q[g-1];
         assign src_data[g] = data_q[g-1];
         assign src_sham[g] = sham_q[g-1];
         assign src_fill[g] = fill_q[g-1];
         assign src_rot[g]  = rot_q[g-1];
         assign src_left[g] = left_q[g-1];
      end

      musb_shift_stage #(
         .WIDTH       (WIDTH),
         .FIRST_LEVEL (FIRST),
         .NUM_LEVELS  (NUM)
      ) u_stage (
         .data_in  (src_data[g]),
         .shamnt   (src_sham[g]),
         .fill     (src_fill[g]),
         .rot      (src_rot[g]),
         .data_out (slice_out[g])
      );

      // The last slice undoes the left-op reversal so out_data is final
      if (g == int'(LAST)) begin : g_unrev
         assign nxt_data[g] = src_left[g] ? bit_rev(slice_out[g]) : slice_out[g];
      end else begin : g_pass
         assign nxt_data[g] = slice_out[g];
      end
   end

   // Backward advance chain: a stage loads when it is empty or moving on
   always_comb begin
      load_ext         = '0;
      adv              = '0;
      load_ext[STAGES] = out_ready;
      for (int i = int'(STAGES) - 1; i >= 0; i--) begin
         adv[i]      = vld_q[i] & load_ext[i+1];
         load_ext[i] = ~vld_q[i] | adv[i];
      end
   end

   assign in_ready  = ~rst & load_ext[0];
   assign out_valid = vld_q[LAST];
   assign out_data  = data_q[LAST];

   // Stage registers: reset clears everything, flush only the valid bits
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         fill_q <= '0;
         rot_q  <= '0;
         left_q <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            data_q[i] <= '0;
            sham_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(STAGES); i++) begin
            if (flush) begin
               vld_q[i] <= 1'b0;
            end else if (load_ext[i]) begin
               vld_q[i] <= src_vld[i];
               if (src_vld[i]) begin
                  data_q[i] <= nxt_data[i];
                  sham_q[i] <= src_sham[i];
                  fill_q[i] <= src_fill[i];
                  rot_q[i]  <= src_rot[i];
                  left_q[i] <= src_left[i];
               end
            end
         end
      end
   end

   // Controls held in the last stage have no further consumer
   logic unused_last;
   assign unused_last = ^{sham_q[LAST], fill_q[LAST], rot_q[LAST], left_q[LAST]};

endmodule

// File: tb/tb_musb_shifter_pipe.sv
// Scoreboard bench for musb_shifter_pipe (WIDTH=32, STAGES=2).
// Define MUSB_SHIFTER_ROTATE_EN to check the rotate build.
module tb_musb_shifter_pipe;

   localparam int W  = 32;
   localparam int ST = 2;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0]  in_data, out_data;
   logic [4:0]    in_shamnt;
   logic [2:0]    in_op;

   musb_shifter_pipe #(
      .WIDTH  (W),
      .STAGES (ST)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamnt (in_shamnt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] data;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pop and compare on every output transfer
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got 0x%08h want none (cycle %0d)",
                        out_data, cyc);
            end else begin
               e = sb.pop_front();
               check("out_data", out_data, e.data);
               if (e.lat) check("latency", 32'(cyc - e.acc), 32'(ST - 1));
            end
         end
      end
   end

   // Issue one op; called and returns at posedge+1
   task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [2:0] op,
                       input logic [31:0] exp_v, input bit lat);
      bit ok;
      ok        = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      in_shamnt = sh;
      in_op     = op;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back('{exp_v, cyc + 1, lat});
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got in_ready 0 want 1 (cycle %0d)", cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int t = 0; t < n; t++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && sb.size() != 0; t++) idle(1);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_data   = '0;
      in_shamnt = '0;
      in_op     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // Directed vectors, back to back with latency checks
      send(32'h8000_0010, 5'd4, 3'b001, 32'hF800_0001, 1'b1);
      send(32'h8000_0010, 5'd4, 3'b000, 32'h0800_0001, 1'b1);
      send(32'h0000_0001, 5'd31, 3'b010, 32'h8000_0000, 1'b1);
      send(32'hDEAD_BEEF, 5'd0, 3'b010, 32'hDEAD_BEEF, 1'b1);
      send(32'h1234_5678, 5'd5, 3'b111, 32'h1234_5678, 1'b1);
`ifdef MUSB_SHIFTER_ROTATE_EN
      send(32'h1234_5678, 5'd8, 3'b100, 32'h7812_3456, 1'b1);
      send(32'h1234_5678, 5'd4, 3'b110, 32'h2345_6781, 1'b1);
`else
      send(32'h1234_5678, 5'd8, 3'b100, 32'h0012_3456, 1'b1);
      send(32'h1234_5678, 5'd4, 3'b110, 32'h2345_6780, 1'b1);
`endif
      send(32'h8000_0000, 5'd31, 3'b001, 32'hFFFF_FFFF, 1'b1);
      drain();

      // Stall: two buffered, third held off until out_ready returns
      out_ready = 1'b0;
      send(32'h8000_0000, 5'd1, 3'b000, 32'h4000_0000, 1'b0);
      send(32'h8000_0000, 5'd2, 3'b000, 32'h2000_0000, 1'b0);
      in_valid  = 1'b1;
      in_data   = 32'h8000_0000;
      in_shamnt = 5'd3;
      in_op     = 3'b000;
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         check("full_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_out_data", out_data, 32'h4000_0000);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(32'h8000_0000, 5'd3, 3'b000, 32'h1000_0000, 1'b0);
      drain();

      // Flush with two in flight and a simultaneous in_valid
      out_ready = 1'b0;
      send(32'h0000_0001, 5'd1, 3'b010, 32'h0000_0002, 1'b0);
      send(32'h0000_0001, 5'd2, 3'b010, 32'h0000_0004, 1'b0);
      in_valid  = 1'b1;
      in_data   = 32'h0000_00AA;
      in_shamnt = 5'd1;
      flush     = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      sb.delete();
      out_ready = 1'b1;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         check("flush_out_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      // Flush while an input actually handshakes into an empty pipe
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         check("flush_in_out_valid", 32'(out_valid), 32'd0);
         @(posedge clk);
         #1;
      end
      send(32'h0000_000F, 5'd4, 3'b010, 32'h0000_00F0, 1'b1);
      drain();

      // Reset with a full, stalled pipe
      out_ready = 1'b0;
      send(32'hFFFF_0000, 5'd4, 3'b000, 32'h0FFF_F000, 1'b0);
      send(32'hFFFF_0000, 5'd8, 3'b000, 32'h00FF_FF00, 1'b0);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("rst_full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_full_out_valid", 32'(out_valid), 32'd0);
      check("rst_full_out_data", out_data, 32'h0);
      check("rst_full_in_ready2", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rst_rel_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      send(32'h0000_0100, 5'd4, 3'b000, 32'h0000_0010, 1'b1);
      drain();
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
